// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with two combinational read
// ports, one synchronous write port, a per-register pending scoreboard for
// hazard detection, and a post-reset clear sequencer that zeroes the array
// one register per cycle (so the array itself needs no reset).
//
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward same-cycle
// write data (and ready=1) to a read port whose address matches the write.
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  output logic              rd1_ready,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  output logic              rd2_ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              pending_any
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  clr_addr;
  logic [DATA_W-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]   pending;

  logic run;
  logic wr_ok;
  logic iss_ok;

  assign run    = (state == RUN);
  // Register 0 is hardwired when ZERO_REG is set: it never accepts a write
  // and never becomes pending.
  assign wr_ok  = run && we       && !(ZERO_REG && (wa == '0));
  assign iss_ok = run && issue_en && !(ZERO_REG && (issue_addr == '0));

  // Clear sequencer: walk every address once after reset, then run forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_addr  <= '0;
      init_busy <= 1'b1;
    end else if (state == INIT) begin
      clr_addr <= clr_addr + ADDR_W'(1);
      if (clr_addr == LAST_ADDR) begin
        state     <= RUN;
        init_busy <= 1'b0;
      end
    end
  end

  // Storage array: zeroed by the sequencer in INIT, written by writeback in RUN.
  // While rst_n is low the state is INIT, so no writeback write can land.
  always_ff @(posedge clk) begin
    if (!run) begin
      regs[clr_addr] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // Scoreboard: writeback clears, issue sets; issue is applied last so it
  // wins when both target the same register (a new producer is in flight).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (run) begin
      if (wr_ok) begin
        pending[wa] <= 1'b0;
      end
      if (iss_ok) begin
        pending[issue_addr] <= 1'b1;
      end
    end
  end

  // Read ports: forced to zero / not-ready while the array is being cleared.
  always_comb begin
    rd1       = '0;
    rd1_ready = 1'b0;
    rd2       = '0;
    rd2_ready = 1'b0;
    if (run) begin
      rd1       = regs[ra1];
      rd1_ready = !pending[ra1];
      rd2       = regs[ra2];
      rd2_ready = !pending[ra2];
`ifdef REGFILE_WRITE_BYPASS_EN
      // Forward the in-flight write; a same-cycle issue does not block it.
      if (wr_ok && (wa == ra1)) begin
        rd1       = wd;
        rd1_ready = 1'b1;
      end
      if (wr_ok && (wa == ra2)) begin
        rd2       = wd;
        rd2_ready = 1'b1;
      end
`endif
      if (ZERO_REG && (ra1 == '0)) begin
        rd1       = '0;
        rd1_ready = 1'b1;
      end
      if (ZERO_REG && (ra2 == '0)) begin
        rd2       = '0;
        rd2_ready = 1'b1;
      end
    end
  end

  assign pending_any = |pending;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard (ZERO_REG=1, DEPTH=32): directed and
// random stimulus, expected outputs from a behavioural model, checked by a
// separate monitor through an expectation queue.
module tb_regfile_scoreboard;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam bit ZR     = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              init_busy;
  logic [ADDR_W-1:0] ra1 = '0;
  logic [DATA_W-1:0] rd1;
  logic              rd1_ready;
  logic [ADDR_W-1:0] ra2 = '0;
  logic [DATA_W-1:0] rd2;
  logic              rd2_ready;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] wa = '0;
  logic [DATA_W-1:0] wd = '0;
  logic              issue_en = 1'b0;
  logic [ADDR_W-1:0] issue_addr = '0;
  logic              pending_any;

  regfile_scoreboard #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_busy   (init_busy),
    .ra1         (ra1),
    .rd1         (rd1),
    .rd1_ready   (rd1_ready),
    .ra2         (ra2),
    .rd2         (rd2),
    .rd2_ready   (rd2_ready),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .pending_any (pending_any)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [7:0] rd1;
    logic       rdy1;
    logic [7:0] rd2;
    logic       rdy2;
    logic       pany;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: register contents, pending flags, clear progress.
  logic [7:0] m_mem  [DEPTH];
  bit         m_pend [DEPTH];
  bit         m_init;
  int         m_cnt;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, want);
    end
  endfunction

  function automatic void mread(input int a, input bit w, input int waddr,
                                input int wdata, output logic [7:0] d,
                                output logic rdy);
    d   = m_mem[a];
    rdy = !m_pend[a];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (w && waddr == a && !(ZR && waddr == 0)) begin
      d   = 8'(wdata);
      rdy = 1'b1;
    end
`endif
    if (ZR && a == 0) begin
      d   = 8'h00;
      rdy = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = 8'h00;
      m_pend[i] = 1'b0;
    end
  endfunction

  // One clock cycle of stimulus: drive, predict, advance the model.
  task automatic step(input bit r, input int a1, input int a2, input bit w,
                      input int waddr, input int wdata, input bit ie,
                      input int ia);
    exp_t e;
    bit   any;
    rst_n      = r;
    ra1        = ADDR_W'(a1);
    ra2        = ADDR_W'(a2);
    we         = w;
    wa         = ADDR_W'(waddr);
    wd         = DATA_W'(wdata);
    issue_en   = ie;
    issue_addr = ADDR_W'(ia);
    e = '0;
    if (!r || m_init) begin
      e.busy = 1'b1;
    end else begin
      any = 1'b0;
      for (int i = 0; i < DEPTH; i++) any |= m_pend[i];
      e.pany = any;
      mread(a1, w, waddr, wdata, e.rd1, e.rdy1);
      mread(a2, w, waddr, wdata, e.rd2, e.rdy2);
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      m_init = 1'b1;
      m_cnt  = 0;
      model_clear();
    end else if (m_init) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_init = 1'b0;
    end else begin
      if (w && !(ZR && waddr == 0)) begin
        m_mem[waddr]  = 8'(wdata);
        m_pend[waddr] = 1'b0;
      end
      if (ie && !(ZR && ia == 0)) m_pend[ia] = 1'b1;
    end
    #1;
  endtask

  function automatic int ra();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, DEPTH - 1));
    return int'($urandom_range(0, 7));
  endfunction

  task automatic rand_step(input bit r);
    step(r, ra(), ra(), bit'($urandom_range(0, 1)), ra(),
         int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), ra());
  endtask

  // Monitor: compare every presented output set against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("init_busy",   32'(init_busy),   32'(e.busy));
      check("rd1",         32'(rd1),         32'(e.rd1));
      check("rd1_ready",   32'(rd1_ready),   32'(e.rdy1));
      check("rd2",         32'(rd2),         32'(e.rd2));
      check("rd2_ready",   32'(rd2_ready),   32'(e.rdy2));
      check("pending_any", 32'(pending_any), 32'(e.pany));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    m_init = 1'b1;
    m_cnt  = 0;
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1;
    // Held reset, then reset again mid-clear at cycle 10.
    repeat (3) rand_step(1'b0);
    repeat (10) rand_step(1'b1);
    repeat (2) rand_step(1'b0);
    // Full clear with ignored writes/issues, then read every address.
    repeat (DEPTH) rand_step(1'b1);
    for (int i = 0; i < DEPTH; i++) step(1, i, DEPTH - 1 - i, 0, 0, 0, 0, 0);
    // Write latency / bypass behaviour.
    step(1, 5, 0, 1, 5, 'hA7, 0, 0);
    step(1, 5, 5, 0, 0, 0, 0, 0);
    // Hazard: issue, observe, resolve by write.
    step(1, 3, 3, 0, 0, 0, 1, 3);
    step(1, 3, 4, 0, 0, 0, 0, 0);
    step(1, 3, 3, 1, 3, 'h11, 0, 0);
    step(1, 3, 3, 0, 0, 0, 0, 0);
    // Same-cycle write and issue to one register: issue wins.
    step(1, 7, 7, 1, 7, 'h3C, 1, 7);
    step(1, 0, 7, 0, 0, 0, 0, 0);
    // Different addresses in the same cycle both take effect.
    step(1, 7, 6, 1, 7, 'h42, 1, 6);
    step(1, 7, 6, 1, 6, 'h24, 0, 0);
    // Hardwired register 0 ignores write and issue.
    step(1, 0, 0, 1, 0, 'hFF, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Reset in RUN with register 9 holding 0x55 and pending.
    step(1, 9, 9, 1, 9, 'h55, 0, 0);
    step(1, 9, 9, 0, 0, 0, 1, 9);
    step(1, 9, 9, 0, 0, 0, 0, 0);
    step(0, 9, 9, 1, 9, 'hEE, 1, 9);
    repeat (DEPTH) step(1, 9, 9, 0, 0, 0, 0, 0);
    step(1, 9, 9, 0, 0, 0, 0, 0);
    // Randomized traffic with rare resets.
    for (int i = 0; i < 500; i++) rand_step($urandom_range(0, 199) != 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor of the CPU register file: 2 async read ports, 1 sync write port, configurable width/depth.
- Adds a per-register pending scoreboard for hazard detection.
- Adds a post-reset sequential clear FSM, so every register reads 0 after reset without an async-reset memory array.
- Sits between decode (issue/read) and writeback (write) in the datapath.

Parameters:
DATA_W, 8, register data width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, when 1 register 0 reads 0 always, ignores writes, never pending

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
init_busy  output  1  high while clear FSM is zeroing registers
ra1  input  ADDR_W  read address port 1
rd1  output  DATA_W  read data port 1 (combinational)
rd1_ready  output  1  register ra1 not pending (data valid)
ra2  input  ADDR_W  read address port 2
rd2  output  DATA_W  read data port 2 (combinational)
rd2_ready  output  1  register ra2 not pending
we  input  1  write enable
wa  input  ADDR_W  write address
wd  input  DATA_W  write data
issue_en  input  1  mark register issue_addr pending (producer in flight)
issue_addr  input  ADDR_W  destination being issued
pending_any  output  1  OR of all pending bits

Behaviour:
- Reset (rst_n=0, async):
  - FSM -> INIT, clear counter = 0, all pending bits = 0.
  - Outputs: init_busy=1, rd1/rd2=0, rd1_ready/rd2_ready=0, pending_any=0.
- FSM state INIT:
  - Each cycle writes 0 to registers[counter], counter++.
  - After counter reaches DEPTH-1 (that clear write included) -> RUN. INIT lasts exactly DEPTH cycles after rst_n rises.
  - we and issue_en ignored.
  - rd1/rd2 forced 0, readyN forced 0, init_busy=1.
- FSM state RUN:
  - init_busy=0. Stays in RUN until next reset.
  - Reset asserted mid-INIT or mid-RUN: immediate return to INIT with counter 0. Any write in flight that cycle is lost.
- Read, combinational:
  - rdN = registers[raN].
  - rdN_ready = !pending[raN].
  - With ZERO_REG=1 and raN=0: rdN=0, ready=1.
- Write, rising edge:
  - If RUN && we && !(ZERO_REG && wa==0): registers[wa] <= wd and pending[wa] <= 0.
  - Latency 1: value visible on rdN the cycle after the write edge.
- Issue, rising edge:
  - If RUN && issue_en && !(ZERO_REG && issue_addr==0): pending[issue_addr] <= 1.
  - Re-issuing an already-pending register is harmless (stays 1).
- Simultaneous write and issue:
  - Same address: data is written, pending ends at 1 (issue wins; new producer outstanding).
  - Different addresses: both take effect.
- Write to a non-pending register is legal: data updated, pending stays 0.
- pending_any: combinational OR of pending[DEPTH-1:0]; 0 in INIT.
- No out-of-range addresses possible (DEPTH = 2**ADDR_W).

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN
- Defined:
  - In RUN, if we && wa==raN (excluding zero reg), rdN = wd and rdN_ready = 1 in the same cycle, regardless of the pending bit.
  - Issue in the same cycle does not suppress the bypass.
- Undefined:
  - rdN returns the old array value; rdN_ready reflects the current pending bit.
  - Write visible next cycle only.

Test Plan:
- Reset then release, DEPTH=32 -> init_busy=1 for exactly 32 cycles then 0. Read all 32 addresses -> rd=0x00, ready=1.
- RUN: write wa=5 wd=0xA7 -> next cycle ra1=5 gives rd1=0xA7. With bypass: rd1=0xA7 in the write cycle. Without bypass: old value 0x00 in the write cycle.
- Hazard sequence:
  - issue_addr=3 -> rd1_ready=0 at ra1=3, pending_any=1.
  - Write wa=3 wd=0x11 -> rd1_ready=1, rd1=0x11, pending_any=0.
- Same-cycle issue_addr=7 and we wa=7 wd=0x3C -> next cycle rd2=0x3C, rd2_ready=0.
- ZERO_REG=1: write wa=0 wd=0xFF and issue_addr=0 -> rd1 at ra1=0 stays 0x00, ready=1, pending_any=0.
- Assert rst_n=0 mid-INIT (cycle 10) and in RUN with reg 9=0x55 pending:
  - Immediate init_busy=1, pending_any=0.
  - After release, full 32-cycle clear; reg 9 reads 0x00, ready=1.
